// File: rtl/kuznechik_pkg.sv
// Shared Kuznechik constants: FSM state encoding, L-transform coefficients, pi table,
// GF(2^8) multiply and the standard round-key schedule.
package kuznechik_pkg;

    localparam int unsigned N_ROUNDS = 10;
    localparam int unsigned BLOCK_W  = 128;

    typedef enum logic [2:0] {StIdle, StKey, StLinv, StSinv, StFinish} state_e;

    typedef logic [255:0][7:0] sbox_t;

    // Forward R coefficients; L_COEF[i] multiplies byte a_i.
    localparam logic [15:0][7:0] L_COEF = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    // pi written in natural order, so pi(x) lives at PI[~x].
    localparam sbox_t PI = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    function automatic sbox_t make_pi_inv();
        sbox_t      inv;
        logic [7:0] v;
        inv = '0;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            inv[PI[~v]] = v;
        end
        return inv;
    endfunction

    // Indexed directly: PI_INV[y] = pi^-1(y).
    localparam sbox_t PI_INV = make_pi_inv();

    // GF(2^8) modulo x^8 + x^7 + x^6 + x + 1.
    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    // Standard schedule for key 8899aabb..0123456789abcdef; entry 0 = K1.
    localparam logic [N_ROUNDS-1:0][BLOCK_W-1:0] DEFAULT_ROUND_KEYS = {
        128'h72e9dd7416bcf45b755dbaa88e4a4043, 128'hbb44e25378c73123a5f32f73cdb6e517,
        128'h5a7925017b9fdd3ed72a91a22286f984, 128'h51e640757e8745de705727265a0098b1,
        128'hbd079435165c6432b532e82834da581b, 128'h57646468c44a5e28d3e59246f429f1ac,
        128'h3d4553d8e9cfec6815ebadc40a9ffd04, 128'hdb31485315694343228d6aef8cc78c44,
        128'hfedcba98765432100123456789abcdef, 128'h8899aabbccddeeff0011223344556677
    };

endpackage

// File: rtl/kuznechik_r_inv_step.sv
// One inverse-R step: shift the block up a byte and append the linear feedback byte.
module kuznechik_r_inv_step
    import kuznechik_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk,
    output logic [BLOCK_W-1:0] res
);

    logic [7:0] fb;

    // Constant-coefficient multipliers reduce to fixed XOR networks.
    always_comb begin
        fb = blk[127:120];
        for (int i = 0; i < 15; i++) begin
            fb = fb ^ gf_mul(blk[8*i +: 8], L_COEF[i+1]);
        end
        res = {blk[119:0], fb};
    end

endmodule

// File: rtl/kuznechik_decipher.sv
// Iterative Kuznechik block decryptor: X[K10], then nine rounds of L^-1, S^-1, X[Ki].
module kuznechik_decipher
    import kuznechik_pkg::*;
#(
    parameter logic [N_ROUNDS-1:0][BLOCK_W-1:0] ROUND_KEYS = DEFAULT_ROUND_KEYS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               request_i,
    input  logic               ack_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [BLOCK_W-1:0] data_o
);

    localparam logic [3:0] LAST_IDX = 4'(N_ROUNDS - 1);

    state_e             state_q;
    logic [BLOCK_W-1:0] blk_q;
    logic [BLOCK_W-1:0] out_q;
    logic [3:0]         idx_q;
    logic [3:0]         cnt_q;
    logic               busy_q;
    logic               valid_q;

    logic [BLOCK_W-1:0] key_blk;
    logic [BLOCK_W-1:0] linv_blk;
    logic [BLOCK_W-1:0] sinv_blk;

    kuznechik_r_inv_step u_r_inv_step (
        .blk (blk_q),
        .res (linv_blk)
    );

    always_comb begin
        key_blk = blk_q ^ ROUND_KEYS[idx_q];
        for (int i = 0; i < 16; i++) begin
            sinv_blk[8*i +: 8] = PI_INV[blk_q[8*i +: 8]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            blk_q   <= '0;
            out_q   <= '0;
            idx_q   <= LAST_IDX;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (request_i) begin
                        blk_q   <= data_i;
                        idx_q   <= LAST_IDX;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= StKey;
                    end
                end
                StKey: begin
                    blk_q <= key_blk;
                    if (idx_q == 4'd0) begin
                        out_q   <= key_blk;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StFinish;
                    end else begin
                        idx_q   <= idx_q - 4'd1;
                        cnt_q   <= '0;
                        state_q <= StLinv;
                    end
                end
                StLinv: begin
                    blk_q <= linv_blk;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_q <= StSinv;
                end
                StSinv: begin
                    blk_q   <= sinv_blk;
                    state_q <= StKey;
                end
                StFinish: begin
                    // A simultaneous ack is absorbed by the restart.
                    if (request_i) begin
                        blk_q   <= data_i;
                        idx_q   <= LAST_IDX;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= StKey;
                    end else if (ack_i) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign data_o  = out_q;

endmodule

// File: tb/tb_kuznechik_decipher.sv
// Scoreboard bench: ciphertexts come from a forward-cipher reference model; a monitor
// checks every rising valid_o against the queued plaintext and its due cycle.
module tb_kuznechik_decipher;

    localparam logic [127:0] C_GOST = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] P_GOST = 128'h1122334455667700ffeeddccbbaa9988;
    localparam int LATENCY = 163;

    localparam logic [2047:0] PI_T = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };
    localparam int LC [16] = '{148, 32, 133, 16, 194, 192, 1, 251,
                               1, 192, 194, 16, 133, 32, 148, 1};
    localparam logic [127:0] RK [10] = '{
        128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
        128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
        128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
        128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043
    };

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         request_i = 1'b0;
    logic         ack_i = 1'b0;
    logic [127:0] data_i = '0;
    logic         busy_o;
    logic         valid_o;
    logic [127:0] data_o;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_valid = 1'b0;

    kuznechik_decipher dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .request_i (request_i),
        .ack_i     (ack_i),
        .data_i    (data_i),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .data_o    (data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference model: forward GOST R 34.12-2015 on plain byte arithmetic.
    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h1C3) << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] pi(input logic [7:0] x);
        int pos;
        pos = 2047 - 8 * int'(x);
        return PI_T[pos -: 8];
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [127:0] st;
        logic [7:0]   x;
        st = p;
        for (int r = 0; r < 9; r++) begin
            st = st ^ RK[r];
            for (int b = 0; b < 16; b++) st[8*b +: 8] = pi(st[8*b +: 8]);
            for (int k = 0; k < 16; k++) begin
                x = '0;
                for (int j = 0; j < 16; j++) x = x ^ gmul(st[8*(15-j) +: 8], LC[j]);
                st = {x, st[127:8]};
            end
        end
        return st ^ RK[9];
    endfunction

    // Monitor: every rising valid_o must match the oldest outstanding block.
    always @(negedge clk) begin
        if (!rst_i && valid_o && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got data_o %h, expected no completion", data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("plaintext", data_o, e.data);
                check("latency_cycle", 128'(cyc), 128'(e.due));
                check("busy_at_valid", 128'(busy_o), 128'(0));
            end
        end
        prev_valid <= valid_o;
    end

    task automatic send(input logic [127:0] ct, input logic [127:0] pt, input logic with_ack);
        exp_t e;
        @(negedge clk);
        request_i = 1'b1;
        ack_i     = with_ack;
        data_i    = ct;
        @(posedge clk);
        #1;
        e.data = pt;
        e.due  = cyc + LATENCY;
        exp_q.push_back(e);
        @(negedge clk);
        request_i = 1'b0;
        ack_i     = 1'b0;
    endtask

    task automatic wait_valid();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < LATENCY + 40 && !seen; k++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL valid_timeout: got no valid_o, expected one within %0d cycles",
                     LATENCY + 40);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] held;
        int           seen_valid;

        repeat (3) @(negedge clk);
        check("reset_busy", 128'(busy_o), 128'(0));
        check("reset_valid", 128'(valid_o), 128'(0));
        check("reset_data", data_o, 128'(0));
        rst_i = 1'b0;

        // GOST vector, then hold the result without ack.
        send(C_GOST, P_GOST, 1'b0);
        wait_valid();
        held = data_o;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check("hold_valid", 128'(valid_o), 128'(1));
            check("hold_data", data_o, P_GOST);
        end
        do_ack();
        check("ack_valid_low", 128'(valid_o), 128'(0));
        check("ack_busy_low", 128'(busy_o), 128'(0));
        check("ack_data_kept", data_o, held);

        // Garbage request 40 cycles into a decryption must be ignored.
        send(C_GOST, P_GOST, 1'b0);
        repeat (38) @(negedge clk);
        check("busy_mid_op", 128'(busy_o), 128'(1));
        request_i = 1'b1;
        data_i    = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        request_i = 1'b0;
        wait_valid();

        // Back-to-back: request and ack together in FINISH.
        pt = {$urandom, $urandom, $urandom, $urandom};
        send(encrypt(pt), pt, 1'b1);
        check("b2b_valid_low", 128'(valid_o), 128'(0));
        check("b2b_busy_high", 128'(busy_o), 128'(1));
        wait_valid();

        // Random round trips with mixed handshakes.
        for (int i = 0; i < 100; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = encrypt(pt);
            if (valid_o && ($urandom_range(0, 1) == 1)) begin
                send(ct, pt, 1'($urandom_range(0, 1)));
            end else begin
                if (valid_o) do_ack();
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(ct, pt, 1'b0);
            end
            wait_valid();
        end
        do_ack();

        // Reset mid-operation aborts the block.
        send(C_GOST, P_GOST, 1'b0);
        repeat (79) @(negedge clk);
        rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_busy", 128'(busy_o), 128'(0));
        check("midrst_valid", 128'(valid_o), 128'(0));
        check("midrst_data", data_o, 128'(0));
        rst_i = 1'b0;
        seen_valid = 0;
        repeat (250) begin
            @(negedge clk);
            if (valid_o) seen_valid++;
        end
        check("no_valid_after_reset", 128'(seen_valid), 128'(0));
        send(C_GOST, P_GOST, 1'b0);
        wait_valid();
        do_ack();
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
